// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes shared with the light sequencer and pedestrian state encodings
package traffic_pkg;
    typedef enum logic [2:0] {RED = 3'b100, GREEN = 3'b010, YELLOW = 3'b001} light_t;
    typedef enum logic [1:0] {IDLE, WALK, CLEAR, FAULT} ped_state_t;
endpackage

// File: rtl/ped_signal_ctrl_if.sv
// ped_signal_ctrl_if: vehicle light/button/tick inputs and pedestrian lamp/display outputs
interface ped_signal_ctrl_if;
    logic [2:0] light;
    logic       ped_btn;
    logic       tick;
    logic       walk;
    logic       dont_walk;
    logic [7:0] cnt_bcd;
    logic       req_pending;
    logic       fault;
    modport master (output light, ped_btn, tick, input walk, dont_walk, cnt_bcd, req_pending, fault);
    modport slave  (input light, ped_btn, tick, output walk, dont_walk, cnt_bcd, req_pending, fault);
endinterface

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: two-digit BCD down counter, load has priority over dec
module bcd_down_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic [7:0] q,
    output logic       is_one
);
    always_ff @(posedge clk) begin
        if (rst) q <= 8'h00;
        else if (load) q <= load_val;
        else if (dec) q <= (q[3:0] == 4'd0) ? {q[7:4] - 4'd1, 4'd9} : {q[7:4], q[3:0] - 4'd1};
    end
    assign is_one = q == 8'h01;
endmodule

// File: rtl/ped_signal_ctrl.sv
// ped_signal_ctrl: pedestrian WALK/DONT_WALK heads with BCD countdown, served on vehicle-red onset
module ped_signal_ctrl
    import traffic_pkg::*;
#(
    parameter logic [7:0] WALK_TIME  = 8'h10,
    parameter logic [7:0] CLEAR_TIME = 8'h07
) (
    input logic              clk,
    input logic              rst,
    ped_signal_ctrl_if.slave bus
);
    ped_state_t state, nxt;
    logic [2:0] light_q;
    logic       req, flash, legal, red_rise, load, dec, is_one;
    logic [7:0] load_val, cnt;

    assign legal    = bus.light inside {RED, GREEN, YELLOW};
    assign red_rise = (bus.light == RED) && (light_q != RED);

    always_comb begin
        nxt = state;
        if (!legal) nxt = FAULT;
        else if (state == FAULT) nxt = (bus.light == RED) ? IDLE : FAULT;
        else if (state inside {WALK, CLEAR} && bus.light != RED) nxt = IDLE;
        else if (state == IDLE && red_rise && (req || bus.ped_btn)) nxt = WALK;
        else if (state == WALK && bus.tick && is_one) nxt = CLEAR;
        else if (state == CLEAR && bus.tick && is_one) nxt = IDLE;
    end

    // Every state change reloads the counter, so IDLE/FAULT always show 00
    assign load     = nxt != state;
    assign load_val = (nxt == WALK) ? WALK_TIME : (nxt == CLEAR) ? CLEAR_TIME : 8'h00;
    assign dec      = bus.tick && !load && (state inside {WALK, CLEAR});

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            light_q <= RED;
            req     <= 1'b0;
            flash   <= 1'b0;
        end else begin
            state   <= nxt;
            light_q <= bus.light;
            req     <= (nxt == WALK && state != WALK) ? 1'b0 :
                       (bus.ped_btn && !(state inside {WALK, FAULT})) ? 1'b1 : req;
            flash   <= (nxt == CLEAR && state != CLEAR) ? 1'b1 :
                       (dec && state == CLEAR) ? !flash : flash;
        end
    end

    bcd_down_counter u_cnt (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .dec(dec), .q(cnt), .is_one(is_one)
    );

    assign bus.walk        = state == WALK;
    assign bus.dont_walk   = (state == CLEAR) ? flash : (state != WALK);
    assign bus.cnt_bcd     = cnt;
    assign bus.req_pending = req;
    assign bus.fault       = state == FAULT;
endmodule

// File: tb/tb_ped_signal_ctrl.sv
// tb_ped_signal_ctrl: directed plus random stimulus on two parameterisations against a decimal model
module tb_ped_signal_ctrl;
    localparam logic [2:0] R = 3'b100, G = 3'b010, Y = 3'b001;
    localparam int P_I = 0, P_W = 1, P_C = 2, P_F = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ped_signal_ctrl_if b0 ();
    ped_signal_ctrl_if b1 ();

    ped_signal_ctrl dut0 (.clk(clk), .rst(rst), .bus(b0));
    ped_signal_ctrl #(.WALK_TIME(8'h01), .CLEAR_TIME(8'h02)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    int checks = 0;
    int errors = 0;
    int ph[2], rem[2], fl[2], rq[2];
    logic [2:0] lq[2];
    int wt[2] = '{10, 1};
    int ct[2] = '{7, 2};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input int k, input logic [2:0] l, input logic b, input logic t, input logic r);
        int  old;
        bit  ew;
        bit  legal;
        old   = ph[k];
        ew    = 0;
        legal = (l == R) || (l == G) || (l == Y);
        if (r) begin
            ph[k] = P_I; rem[k] = 0; fl[k] = 0; rq[k] = 0; lq[k] = R;
        end else begin
            if (!legal) begin
                ph[k] = P_F; rem[k] = 0;
            end else if (old == P_F) begin
                if (l == R) ph[k] = P_I;
            end else if ((old == P_W || old == P_C) && l != R) begin
                ph[k] = P_I; rem[k] = 0;
            end else if (old == P_I) begin
                if (l == R && lq[k] != R && (rq[k] != 0 || b)) begin
                    ph[k] = P_W; rem[k] = wt[k]; ew = 1;
                end
            end else if (old == P_W && t) begin
                if (rem[k] == 1) begin ph[k] = P_C; rem[k] = ct[k]; fl[k] = 1; end
                else rem[k]--;
            end else if (old == P_C && t) begin
                if (rem[k] == 1) begin ph[k] = P_I; rem[k] = 0; end
                else begin rem[k]--; fl[k] = 1 - fl[k]; end
            end
            if (ew) rq[k] = 0;
            else if (b && old != P_W && old != P_F) rq[k] = 1;
            lq[k] = l;
        end
    endtask

    task automatic compare(input int k);
        logic [7:0] bcd;
        bcd = {4'(rem[k] / 10), 4'(rem[k] % 10)};
        chk($sformatf("d%0d.walk", k), 8'(k == 0 ? b0.walk : b1.walk), 8'(ph[k] == P_W));
        chk($sformatf("d%0d.dont_walk", k), 8'(k == 0 ? b0.dont_walk : b1.dont_walk),
            8'(ph[k] == P_C ? fl[k] != 0 : ph[k] != P_W));
        chk($sformatf("d%0d.cnt", k), k == 0 ? b0.cnt_bcd : b1.cnt_bcd, bcd);
        chk($sformatf("d%0d.req", k), 8'(k == 0 ? b0.req_pending : b1.req_pending), 8'(rq[k] != 0));
        chk($sformatf("d%0d.fault", k), 8'(k == 0 ? b0.fault : b1.fault), 8'(ph[k] == P_F));
    endtask

    task automatic step(input logic [2:0] l, input logic b, input logic t, input logic r);
        b0.light = l; b1.light = l;
        b0.ped_btn = b; b1.ped_btn = b;
        b0.tick = t; b1.tick = t;
        rst = r;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model(k, l, b, t, r);
        #1;
        for (int k = 0; k < 2; k++) compare(k);
    endtask

    initial begin
        logic [2:0] cur;
        int         sel;
        // T1 reset
        step(R, 0, 0, 1);
        step(R, 0, 0, 1);
        chk("rst.walk", 8'(b0.walk), 8'h00);
        chk("rst.dont_walk", 8'(b0.dont_walk), 8'h01);
        chk("rst.cnt", b0.cnt_bcd, 8'h00);
        chk("rst.req", 8'(b0.req_pending), 8'h00);
        chk("rst.fault", 8'(b0.fault), 8'h00);
        // T2 served request
        step(G, 0, 0, 0);
        step(G, 1, 0, 0);
        step(G, 0, 0, 0);
        chk("t2.req_set", 8'(b0.req_pending), 8'h01);
        step(Y, 0, 0, 0);
        step(R, 0, 0, 0);
        chk("t2.walk_on_red", 8'(b0.walk), 8'h01);
        chk("t2.cnt_load", b0.cnt_bcd, 8'h10);
        chk("t2.req_clr", 8'(b0.req_pending), 8'h00);
        for (int i = 0; i < 10; i++) begin
            step(R, 0, 1, 0);
            if (i == 0) chk("t6.borrow", b0.cnt_bcd, 8'h09);
            step(R, 0, 0, 0);
        end
        chk("t2.clear_cnt", b0.cnt_bcd, 8'h07);
        chk("t2.clear_flash", 8'(b0.dont_walk), 8'h01);
        chk("t2.clear_walk", 8'(b0.walk), 8'h00);
        for (int i = 0; i < 7; i++) begin
            step(R, 0, 1, 0);
            if (i == 0) chk("t2.flash_toggle", 8'(b0.dont_walk), 8'h00);
        end
        chk("t2.idle_cnt", b0.cnt_bcd, 8'h00);
        chk("t2.idle_dw", 8'(b0.dont_walk), 8'h01);
        // T3 safety abort at cnt 06
        step(G, 1, 0, 0);
        step(Y, 0, 0, 0);
        step(R, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(R, 0, 1, 0);
        chk("t3.cnt06", b0.cnt_bcd, 8'h06);
        step(G, 0, 0, 0);
        chk("t3.abort_walk", 8'(b0.walk), 8'h00);
        chk("t3.abort_cnt", b0.cnt_bcd, 8'h00);
        // T4 red without request, then mid-red press
        step(Y, 0, 0, 0);
        step(R, 0, 0, 0);
        chk("t4.no_req", 8'(b0.walk), 8'h00);
        step(R, 1, 0, 0);
        step(R, 0, 0, 0);
        chk("t4.mid_red", 8'(b0.walk), 8'h00);
        step(G, 0, 0, 0);
        step(Y, 0, 0, 0);
        step(R, 0, 0, 0);
        chk("t4.next_red", 8'(b0.walk), 8'h01);
        // T5 fault
        step(3'b011, 0, 0, 0);
        chk("t5.fault", 8'(b0.fault), 8'h01);
        chk("t5.walk", 8'(b0.walk), 8'h00);
        step(G, 0, 0, 0);
        chk("t5.hold", 8'(b0.fault), 8'h01);
        step(R, 0, 0, 0);
        chk("t5.release", 8'(b0.fault), 8'h00);
        // T6 tick coincident with entry, and one-tick WALK on dut1
        step(G, 1, 0, 0);
        step(Y, 0, 0, 0);
        step(R, 0, 1, 0);
        chk("t6.entry_tick", b0.cnt_bcd, 8'h10);
        chk("t6.w1_entry", b1.cnt_bcd, 8'h01);
        step(R, 0, 1, 0);
        chk("t6.w1_walk", 8'(b1.walk), 8'h00);
        chk("t6.w1_clear", b1.cnt_bcd, 8'h02);
        step(G, 0, 0, 0);
        // random phase
        cur = G;
        for (int i = 0; i < 500; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 4) cur = 3'($urandom_range(0, 7));
            else if (sel < 30) begin
                case ($urandom_range(0, 2))
                    0: cur = R;
                    1: cur = G;
                    default: cur = Y;
                endcase
            end
            step(cur, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 45, $urandom_range(0, 199) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
